// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, FSM states
// and the alignment check applied to incoming requests.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WRITE,
        RESP
    } state_e;

    function automatic logic is_misaligned(input size_e size, input logic [1:0] off);
        case (size)
            SZ_HALF: return off[0];
            SZ_WORD: return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane datapath: extracts and extends load data from a memory word, and
// merges right-aligned store data into an existing word for sub-word stores.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  size_e       size_i,
    input  logic        signed_i,
    input  logic [1:0]  off_i,
    output logic [31:0] rdata_o,
    output logic [31:0] merged_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v   = word_i[7:0];
        half_v   = off_i[1] ? word_i[31:16] : word_i[15:0];
        rdata_o  = '0;
        merged_o = word_i;
        case (off_i)
            2'd0:    byte_v = word_i[7:0];
            2'd1:    byte_v = word_i[15:8];
            2'd2:    byte_v = word_i[23:16];
            default: byte_v = word_i[31:24];
        endcase
        case (size_i)
            SZ_BYTE: begin
                rdata_o = {{24{signed_i & byte_v[7]}}, byte_v};
                case (off_i)
                    2'd0:    merged_o[7:0]   = wdata_i[7:0];
                    2'd1:    merged_o[15:8]  = wdata_i[7:0];
                    2'd2:    merged_o[23:16] = wdata_i[7:0];
                    default: merged_o[31:24] = wdata_i[7:0];
                endcase
            end
            SZ_HALF: begin
                rdata_o = {{16{signed_i & half_v[15]}}, half_v};
                if (off_i[1]) merged_o[31:16] = wdata_i[15:0];
                else          merged_o[15:0]  = wdata_i[15:0];
            end
            SZ_WORD: begin
                rdata_o  = word_i;
                merged_o = wdata_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the MIPS memory stage and a word-wide single-port
// data memory: sub-word loads, read-modify-write stores, alignment errors.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_A,
    output logic [31:0] mem_WD,
    output logic        mem_WE,
    input  logic [31:0] mem_RD
);

    state_e      state_q, state_d;
    logic        we_q, we_d;
    size_e       size_q, size_d;
    logic        sgn_q, sgn_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] merged_q, merged_d;
    logic        err_q, err_d;
    logic [31:0] lane_rdata, lane_merged;
    size_e       req_size_e;

    assign req_size_e = size_e'(req_size);

    lsu_lane u_lane (
        .word_i   (mem_RD),
        .wdata_i  (wdata_q),
        .size_i   (size_q),
        .signed_i (sgn_q),
        .off_i    (addr_q[1:0]),
        .rdata_o  (lane_rdata),
        .merged_o (lane_merged)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            size_q   <= SZ_BYTE;
            sgn_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            merged_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            size_q   <= size_d;
            sgn_q    <= sgn_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            merged_q <= merged_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        size_d    = size_q;
        sgn_d     = sgn_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        merged_d  = merged_q;
        err_d     = err_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        mem_WE    = 1'b0;
        mem_WD    = '0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size_e;
                    sgn_d   = req_signed;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    err_d   = (req_size_e == SZ_ILL) || is_misaligned(req_size_e, req_addr[1:0]);
                    state_d = err_d ? RESP : ACCESS;
                end
            end
            // Write enables are masked by rst so an abandoned store cannot land on the reset edge.
            ACCESS: begin
                if (!we_q) begin
                    rdata_d = lane_rdata;
                    state_d = RESP;
                end else if (size_q == SZ_WORD) begin
                    mem_WE  = !rst;
                    mem_WD  = wdata_q;
                    state_d = RESP;
                end else begin
                    merged_d = lane_merged;
                    state_d  = WRITE;
                end
            end
            WRITE: begin
                mem_WE  = !rst;
                mem_WD  = merged_q;
                state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_A     = {2'b00, addr_q[31:2]};
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a small word memory attached and
// a reference model computing loads, stores and errors from byte arithmetic.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata, mem_A, mem_WD, mem_RD;
    logic        mem_WE;

    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
    );

    assign mem_RD = mem[mem_A[5:0]];
    always @(posedge clk) if (mem_WE) mem[mem_A[5:0]] <= mem_WD;

    // ---------------- reference model ----------------
    function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                               input logic sg, input logic [1:0] off);
        logic [31:0] s;
        s = w >> (8 * off);
        if (sz == 2'd0) return (sg && s[7])  ? (s & 32'hFF)   | 32'hFFFFFF00 : s & 32'hFF;
        if (sz == 2'd1) return (sg && s[15]) ? (s & 32'hFFFF) | 32'hFFFF0000 : s & 32'hFFFF;
        return w;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [1:0] sz, input logic [1:0] off);
        logic [31:0] m;
        m = (sz == 2'd0) ? (32'hFF << (8 * off)) : (sz == 2'd1) ? (32'hFFFF << (8 * off)) : 32'hFFFFFFFF;
        return (old & ~m) | ((wd << (8 * off)) & m);
    endfunction

    task automatic init_mem();
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[2] = 32'h0F0F0F0F; ref_mem[2] = 32'h0F0F0F0F;
        mem[3] = 32'h000000F0; ref_mem[3] = 32'h000000F0;
    endtask

    // Issue one request, accept the response immediately, report what was seen.
    // lat = cycle of first rsp_valid (-1 if none); wemask bit c = mem_WE in cycle c.
    task automatic run_req(input logic we, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] rd, output logic er, output int lat,
                           output int wemask);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = $urandom; req_size = $urandom; req_signed = $urandom;
        req_addr = $urandom; req_wdata = $urandom;
        if (!we) ref_mem[a[7:2]] = ref_mem[a[7:2]];
        else if (!model_err(sz, a)) ref_mem[a[7:2]] = model_store(ref_mem[a[7:2]], wd, sz, a[1:0]);
        lat = -1; wemask = 0; rd = 'x; er = 1'bx;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (mem_WE) wemask |= (1 << c);
            if (rsp_valid) begin
                lat = c; rd = rsp_rdata; er = rsp_err;
                rsp_ready = 1'b1;
                @(posedge clk); #1;
                rsp_ready = 1'b0;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; req_valid = 0; req_we = 0; req_size = 0; req_signed = 0;
        req_addr = 0; req_wdata = 0; rsp_ready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0; #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
        checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); end
        checks++; if (mem_WE !== 1'b0) begin errors++; $display("FAIL reset_mem_WE got=%b exp=0", mem_WE); end
        checks++; if (mem_WD !== 32'h0) begin errors++; $display("FAIL reset_mem_WD got=%h exp=0", mem_WD); end
        checks++; if (mem_A !== 32'h0) begin errors++; $display("FAIL reset_mem_A got=%h exp=0", mem_A); end
    endtask

    task automatic test_byte_load();
        logic [31:0] rd; logic er; int lat, wm;
        init_mem();
        run_req(1'b0, 2'd0, 1'b1, 32'h0C, 32'h0, rd, er, lat, wm);
        checks++; if (rd !== 32'hFFFFFFF0) begin errors++; $display("FAIL lb_rdata got=%h exp=fffffff0", rd); end
        checks++; if (er !== 1'b0 || lat != 2 || wm != 0) begin errors++; $display("FAIL lb_timing err=%b lat=%0d we=%0h exp err=0 lat=2 we=0", er, lat, wm); end
        run_req(1'b0, 2'd0, 1'b0, 32'h0C, 32'h0, rd, er, lat, wm);
        checks++; if (rd !== 32'h000000F0) begin errors++; $display("FAIL lbu_rdata got=%h exp=000000f0", rd); end
        checks++; if (er !== 1'b0 || lat != 2 || wm != 0) begin errors++; $display("FAIL lbu_timing err=%b lat=%0d we=%0h exp err=0 lat=2 we=0", er, lat, wm); end
    endtask

    task automatic test_byte_store();
        logic [31:0] rd; logic er; int lat, wm;
        init_mem();
        run_req(1'b1, 2'd0, 1'b0, 32'h09, 32'h000000AB, rd, er, lat, wm);
        checks++; if (wm != 4 || lat != 3 || er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL sb_timing we=%0h lat=%0d err=%b rd=%h exp we=4 lat=3 err=0 rd=0", wm, lat, er, rd); end
        checks++; if (mem[2] !== 32'h0F0FAB0F) begin errors++; $display("FAIL sb_mem got=%h exp=0f0fab0f", mem[2]); end
        run_req(1'b0, 2'd2, 1'b0, 32'h08, 32'h0, rd, er, lat, wm);
        checks++; if (rd !== 32'h0F0FAB0F || lat != 2) begin errors++; $display("FAIL sb_lw got=%h lat=%0d exp=0f0fab0f lat=2", rd, lat); end
    endtask

    task automatic test_half();
        logic [31:0] rd; logic er; int lat, wm;
        init_mem();
        run_req(1'b1, 2'd1, 1'b0, 32'h0E, 32'h00001234, rd, er, lat, wm);
        checks++; if (mem[3] !== 32'h123400F0 || wm != 4 || lat != 3) begin errors++; $display("FAIL sh_mem got=%h we=%0h lat=%0d exp=123400f0 we=4 lat=3", mem[3], wm, lat); end
        run_req(1'b0, 2'd1, 1'b0, 32'h0E, 32'h0, rd, er, lat, wm);
        checks++; if (rd !== 32'h00001234) begin errors++; $display("FAIL lhu_rdata got=%h exp=00001234", rd); end
        run_req(1'b0, 2'd1, 1'b1, 32'h0C, 32'h0, rd, er, lat, wm);
        checks++; if (rd !== 32'h000000F0) begin errors++; $display("FAIL lh_rdata got=%h exp=000000f0", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat, wm;
        logic        wes [3] = '{1'b0, 1'b1, 1'b0};
        logic [1:0]  szs [3] = '{2'd2, 2'd1, 2'd3};
        logic [31:0] ads [3] = '{32'h0A, 32'h09, 32'h08};
        init_mem();
        for (int i = 0; i < 3; i++) begin
            run_req(wes[i], szs[i], 1'b1, ads[i], 32'hDEADBEEF, rd, er, lat, wm);
            checks++; if (er !== 1'b1 || lat != 1 || wm != 0 || rd !== 32'h0) begin errors++; $display("FAIL err_case%0d err=%b lat=%0d we=%0h rd=%h exp err=1 lat=1 we=0 rd=0", i, er, lat, wm, rd); end
        end
        for (int i = 0; i < 64; i++) begin
            checks++; if (mem[i] !== ref_mem[i]) begin errors++; $display("FAIL err_mem[%0d] got=%h exp=%h", i, mem[i], ref_mem[i]); end
        end
    endtask

    task automatic test_backpressure();
        int seen;
        init_mem();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h08; rsp_ready = 1'b0;
        @(posedge clk); #1; req_valid = 1'b0;
        seen = -1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (rsp_valid) begin seen = c; break; end
        end
        checks++; if (seen != 2) begin errors++; $display("FAIL bp_latency got=%0d exp=2", seen); end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0F0F0F0F || req_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold%0d valid=%b rdata=%h ready=%b exp 1 0f0f0f0f 0", k, rsp_valid, rsp_rdata, req_ready);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_after ready=%b valid=%b exp 1 0", req_ready, rsp_valid); end
    endtask

    task automatic test_reset_mid_write();
        init_mem();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0; req_addr = 32'h0C; req_wdata = 32'h55; rsp_ready = 1'b0;
        @(posedge clk); #1; req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (mem_WE !== 1'b1) begin errors++; $display("FAIL rst_mid_we_before got=%b exp=1", mem_WE); end
        rst = 1'b1; #1;
        checks++; if (mem_WE !== 1'b0) begin errors++; $display("FAIL rst_mid_we_masked got=%b exp=0", mem_WE); end
        @(negedge clk); rst = 1'b0; #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_idle ready=%b exp=1", req_ready); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (rsp_valid !== 1'b0 || mem_WE !== 1'b0) begin errors++; $display("FAIL rst_mid_quiet%0d valid=%b we=%b exp 0 0", k, rsp_valid, mem_WE); end
            @(negedge clk);
        end
        checks++; if (mem[3] !== 32'h000000F0) begin errors++; $display("FAIL rst_mid_mem got=%h exp=000000f0", mem[3]); end
    endtask

    task automatic test_random();
        logic [31:0] rd, a, wd, exp_rd; logic er, we, sg, exp_er; logic [1:0] sz;
        int lat, wm, exp_lat, exp_wm;
        init_mem();
        for (int n = 0; n < 60; n++) begin
            we = $urandom_range(0, 1); sg = $urandom_range(0, 1);
            sz = 2'($urandom_range(0, 3)); a = 32'($urandom_range(0, 255)); wd = $urandom;
            exp_er = model_err(sz, a);
            exp_rd = (we || exp_er) ? 32'h0 : model_load(ref_mem[a[7:2]], sz, sg, a[1:0]);
            exp_lat = exp_er ? 1 : (we && sz != 2'd2) ? 3 : 2;
            exp_wm  = (exp_er || !we) ? 0 : (sz == 2'd2) ? 2 : 4;
            run_req(we, sz, sg, a, wd, rd, er, lat, wm);
            checks++;
            if (rd !== exp_rd || er !== exp_er || lat != exp_lat || wm != exp_wm) begin
                errors++;
                $display("FAIL rand%0d we=%b sz=%0d a=%h rd=%h err=%b lat=%0d wem=%0h exp rd=%h err=%b lat=%0d wem=%0h",
                         n, we, sz, a, rd, er, lat, wm, exp_rd, exp_er, exp_lat, exp_wm);
            end
            checks++; if (mem[a[7:2]] !== ref_mem[a[7:2]]) begin errors++; $display("FAIL rand%0d_mem got=%h exp=%h", n, mem[a[7:2]], ref_mem[a[7:2]]); end
        end
    endtask

    initial begin
        init_mem();
        test_reset();
        test_byte_load();
        test_byte_store();
        test_half();
        test_errors();
        test_backpressure();
        test_reset_mid_write();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the MIPS execute/memory pipeline stage and the word-wide, single-port data memory. Converts byte-addressed load/store requests of byte, halfword and word size into word-addressed memory accesses. Extracts and extends load data, and performs read-modify-write for sub-word stores. Flags misaligned or illegal requests without touching memory.

## Interface
- No parameters. Memory word width is 32 bits; data is little-endian.
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid  out  1  response available; held until accepted
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  32  load result, extended; 0 for stores and errors
- rsp_err  out  1  misaligned or illegal request
- mem_A  out  32  word address to data memory, {2'b00, addr[31:2]}
- mem_WD  out  32  write data to data memory
- mem_WE  out  1  write enable to data memory
- mem_RD  in  32  combinational read data from data memory at mem_A

## Operation
- States: IDLE, ACCESS, WRITE, RESP.
- IDLE: req_ready=1. When req_valid is high, register we/size/signed/addr/wdata.
  - If the request is an error, go to RESP with err=1.
  - Otherwise go to ACCESS.
- Error conditions:
  - size==11.
  - half with addr[0]=1.
  - word with addr[1:0]≠0.
- ACCESS: mem_A is driven from the registered address.
  - Load: capture the extracted lane from mem_RD, then go to RESP.
  - Word store: mem_WE=1, mem_WD=wdata, then go to RESP.
  - Sub-word store: latch merged word = mem_RD with the selected lane replaced, then go to WRITE.
- WRITE: mem_WE=1, mem_WD=merged word, mem_A unchanged, then go to RESP.
- RESP: rsp_valid=1 with rdata/err stable. When rsp_ready is high, go to IDLE.
- Lane select:
  - Byte: lane addr[1:0], bits [8k+7:8k].
  - Half: addr[1]=0 selects [15:0], addr[1]=1 selects [31:16].
- Extension: signed uses the lane MSB; unsigned zero-fills.
- Loads never assert mem_WE. Errors never drive mem_WE and issue no memory access.
- mem_A holds the last registered address whenever mem_WE=0; its value in IDLE is don't-care.

## Timing
- Request accepted at edge 0. Cycles are counted from the accept edge.
- Load: ACCESS in cycle 1; rsp_valid first high in cycle 2. Latency is 2.
- Word store: mem_WE high in cycle 1; rsp_valid in cycle 2.
- Sub-word store: read in cycle 1, mem_WE high in cycle 2, rsp_valid in cycle 3.
- Error: rsp_valid in cycle 1.
- Back-pressure: rsp_valid stays high for as long as rsp_ready stays low.
- After the response handshake, req_ready is high in the next cycle. A request and a response never complete in the same cycle.
- Reset values:
  - State is IDLE.
  - rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - mem_WE=0, mem_WD=0, mem_A=0.
  - req_ready=1 in the first cycle after reset deasserts.
- Reset mid-operation (ACCESS/WRITE/RESP): the operation is abandoned. No write occurs on the reset edge or afterwards, and no response is issued.
- req_valid while not in IDLE is ignored. Request inputs need not stay stable after the accept edge.

## Structure
- lsu_pkg:
  - size enum (SZ_BYTE, SZ_HALF, SZ_WORD).
  - state enum (IDLE, ACCESS, WRITE, RESP).
  - Function is_misaligned(size, addr[1:0]).
- Sub-module lsu_lane: purely combinational.
  - Load path: extract + extend from (word, size, signed, addr[1:0]).
  - Store path: merge from (old word, wdata, size, addr[1:0]).
  - The FSM and registers live in load_store_unit.

## Test plan
Each scenario uses the unit connected to data memory initialised with mem[2]=0x0F0F0F0F and mem[3]=0x000000F0.

- lb at 0x0C, then lbu at 0x0C: rdata 0xFFFFFFF0 and 0x000000F0; rsp_valid in cycle 2 of each request; err=0.
- sb 0x000000AB at 0x09: mem_WE only in cycle 2; mem[2] becomes 0x0F0FAB0F. A following lw at 0x08 returns 0x0F0FAB0F.
- sh 0x00001234 at 0x0E, then lhu at 0x0E: mem[3] becomes 0x123400F0 and the load returns 0x00001234. lh at 0x0C returns 0x000000F0.
- lw at 0x0A, sh at 0x09, and size=11 at 0x08: each gives err=1 in cycle 1, rdata=0, no mem_WE pulse, and memory unchanged.
- Hold rsp_ready=0 for 5 cycles after a lw at 0x08: rsp_valid and rdata 0x0F0F0F0F stay stable and req_ready stays 0. After the handshake, req_ready=1 in the next cycle.
- Assert rst during WRITE of an sb at 0x0C: no write occurs, mem[3] is unchanged, rsp_valid stays 0, and the unit is in IDLE after reset.
